// File: rtl/apb_requester.sv
// apb_requester: APB-style initiator that turns the core's single-request
// load/store port into SETUP/ACCESS bus transfers.
//
// The upper SEL_W address bits pick one of NUM_SLV slaves (one-hot P_SEL).
// The requester then waits in ACCESS for that slave's PREADY. A wait-cycle
// counter aborts the transfer with cpu_err after TIMEOUT ACCESS cycles, so a
// dead slave cannot stall the core. TIMEOUT=0 disables the abort.
//
// Ports
//   clock, rst              bus clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata   request from core, sampled only while cpu_ready=1
//   cpu_ready               idle, a request will be accepted this cycle
//   cpu_done                one-cycle completion pulse
//   cpu_rdata               read data, held until the next completion
//   cpu_err                 with cpu_done: transfer aborted by timeout
//   P_SEL, P_EN             one-hot slave select, access-phase enable
//   PWRITE, PADDR, PWDATA   direction/address/write data, stable per transfer
//   PREADY, PRDATA          per-slave ready and read data (slave i at
//                           PRDATA[i*DATA_W +: DATA_W])
module apb_requester #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic                         cpu_ready,
  output logic                         cpu_done,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_err,
  output logic [(1<<SEL_W)-1:0]        P_SEL,
  output logic                         P_EN,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [(1<<SEL_W)-1:0]        PREADY,
  input  logic [(1<<SEL_W)*DATA_W-1:0] PRDATA
);

  localparam int NUM_SLV = 1 << SEL_W;
  // The counter only ever reaches TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic                 pen_q, pen_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;

  logic                 pready_sel;
  logic [DATA_W-1:0]    prdata_sel;
  logic                 timeout_hit;
  logic [SEL_W-1:0]     req_sel;

  // Only the latched slave is observed; other PREADY bits are don't-care.
  assign pready_sel  = PREADY[sel_q];
  assign prdata_sel  = PRDATA[int'(sel_q)*DATA_W +: DATA_W];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign req_sel     = cpu_addr[ADDR_W-1 -: SEL_W];

  // State and output registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      psel_q   <= '0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_sel || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Each value is
  // computed one cycle ahead so it appears together with the new state.
  always_comb begin
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    case (state_q)
      IDLE: begin
        psel_d  = '0;
        pen_d   = 1'b0;
        ready_d = 1'b1;
        if (cpu_req) begin
          paddr_d         = cpu_addr;
          pwdata_d        = cpu_wdata;
          pwrite_d        = cpu_we;
          sel_d           = req_sel;
          cnt_d           = '0;
          ready_d         = 1'b0;
          psel_d          = '0;
          psel_d[req_sel] = 1'b1;
        end
      end
      SETUP: begin
        pen_d = 1'b1;
      end
      ACCESS: begin
        // PREADY takes priority over a simultaneous timeout.
        if (pready_sel) begin
          if (!pwrite_q) rdata_d = prdata_sel;
          done_d  = 1'b1;
          ready_d = 1'b1;
          psel_d  = '0;
          pen_d   = 1'b0;
        end else if (timeout_hit) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
          ready_d = 1'b1;
          psel_d  = '0;
          pen_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        psel_d  = '0;
        pen_d   = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign cpu_ready = ready_q;
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign P_SEL     = psel_q;
  assign P_EN      = pen_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_requester.sv
module tb_apb_requester;

  localparam int TMO = 4;

  logic        clock;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [15:0] cpu_rdata;
  logic        cpu_err;
  logic [3:0]  P_SEL;
  logic        P_EN;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [15:0] PWDATA;
  logic [3:0]  PREADY;
  logic [63:0] PRDATA;

  apb_requester #(
    .ADDR_W(16), .DATA_W(16), .SEL_W(2), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .P_SEL(P_SEL), .P_EN(P_EN), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One transfer: waits = ACCESS cycles before the slave raises PREADY
  // (>= TMO means never), other = PREADY bits of the non-selected slaves,
  // b2b = next transfer is requested in this one's done cycle.
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          waits;
    logic [3:0]  other;
    bit          b2b;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_bad;
  logic [15:0] last_rdata;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_slave(input vec_t v, input int sel, input int c);
    logic [3:0] oh;
    oh = 4'b0001 << sel;
    PREADY = v.other & ~oh;
    if (v.waits < 50 && c >= 2 + v.waits) PREADY[sel] = 1'b1;
    for (int i = 0; i < 4; i++)
      PRDATA[i*16 +: 16] = (i == sel) ? v.rdata : ~v.rdata;
  endtask

  // Starts in a cycle where the requester should be ready; returns while
  // still inside the cycle the done pulse is expected.
  task automatic run_txn(input vec_t v);
    int         sel;
    logic [3:0] oh;
    exp_t       e;
    exp_t       g;
    bit         got;
    sel = int'(v.addr[15:14]);
    oh  = 4'b0001 << sel;
    if (v.waits >= TMO) begin
      e.cyc = 2 + TMO; e.err = 1'b1; e.rdata = 16'h0000;
    end else begin
      e.cyc = 3 + v.waits; e.err = 1'b0; e.rdata = v.we ? last_rdata : v.rdata;
    end
    last_rdata = e.rdata;
    sb.push_back(e);
    chk("ready_at_req", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    drive_slave(v, sel, 0);
    got = 1'b0;
    for (int c = 1; c <= e.cyc + 2 && !got; c++) begin
      step();
      cpu_req = 1'b0;
      drive_slave(v, sel, c);
      if (c <= e.cyc) begin
        chk("psel",   32'(P_SEL),   32'((c < e.cyc) ? oh : 4'b0000));
        chk("pen",    32'(P_EN),    32'((c >= 2 && c < e.cyc) ? 1'b1 : 1'b0));
        chk("paddr",  32'(PADDR),   32'(v.addr));
        chk("pwrite", 32'(PWRITE),  32'(v.we));
        chk("pwdata", 32'(PWDATA),  32'(v.wdata));
        chk("ready",  32'(cpu_ready), 32'((c == e.cyc) ? 1'b1 : 1'b0));
      end
      if (cpu_done) begin
        g = sb.pop_front();
        chk("latency", 32'(c), 32'(g.cyc));
        chk("rdata",   32'(cpu_rdata), 32'(g.rdata));
        chk("err",     32'(cpu_err),   32'(g.err));
        got = 1'b1;
      end else begin
        chk("err_idle", 32'(cpu_err), 32'd0);
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL no_done: got none expected done in cycle %0d", e.cyc);
      void'(sb.pop_front());
    end
    PREADY = 4'b0000;
  endtask

  vec_t tbl[9];
  vec_t post_rst;

  initial begin
    n_cmp = 0; n_bad = 0; last_rdata = 16'h0000;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    PREADY = '0; PRDATA = '0;

    //          we    addr      wdata     rdata     waits other    b2b
    tbl[0] = '{1'b1, 16'h4010, 16'hBEEF, 16'hDEAD, 0,    4'b0000, 1'b0}; // zero-wait write
    tbl[1] = '{1'b0, 16'hC004, 16'h0000, 16'h1234, 3,    4'b0000, 1'b0}; // waited read, ready ties timeout
    tbl[2] = '{1'b0, 16'h0020, 16'h1111, 16'h9999, 99,   4'b0000, 1'b0}; // timeout
    tbl[3] = '{1'b1, 16'h8000, 16'h5A5A, 16'h3C3C, 1,    4'b0000, 1'b1}; // write, then back-to-back
    tbl[4] = '{1'b0, 16'h8002, 16'h0000, 16'hA55A, 0,    4'b0000, 1'b1};
    tbl[5] = '{1'b0, 16'h0100, 16'h0000, 16'h0F0F, 2,    4'b0000, 1'b0};
    tbl[6] = '{1'b0, 16'h4444, 16'h0000, 16'h7777, 2,    4'b1101, 1'b0}; // select isolation
    tbl[7] = '{1'b0, 16'h3FFE, 16'h0000, 16'hCAFE, 3,    4'b1110, 1'b0};
    tbl[8] = '{1'b1, 16'hFFFF, 16'h6B6B, 16'h2222, 99,   4'b0000, 1'b0}; // write timeout clears rdata

    step(); step();
    chk("rst_ready",  32'(cpu_ready), 32'd1);
    chk("rst_done",   32'(cpu_done),  32'd0);
    chk("rst_err",    32'(cpu_err),   32'd0);
    chk("rst_rdata",  32'(cpu_rdata), 32'd0);
    chk("rst_psel",   32'(P_SEL),     32'd0);
    chk("rst_pen",    32'(P_EN),      32'd0);
    chk("rst_pwrite", 32'(PWRITE),    32'd0);
    chk("rst_paddr",  32'(PADDR),     32'd0);
    chk("rst_pwdata", 32'(PWDATA),    32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i]);
      if (!tbl[i].b2b) begin
        step();
        chk("done_pulse", 32'(cpu_done), 32'd0);
        chk("err_pulse",  32'(cpu_err),  32'd0);
        step();
      end
    end

    // Reset in the middle of a waited read on slave 2
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8006; cpu_wdata = 16'h0000;
    PREADY = 4'b0000;
    step();
    cpu_req = 1'b0;
    step(); step();
    chk("pre_rst_pen", 32'(P_EN), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_psel",  32'(P_SEL),     32'd0);
    chk("arst_pen",   32'(P_EN),      32'd0);
    chk("arst_paddr", 32'(PADDR),     32'd0);
    chk("arst_ready", 32'(cpu_ready), 32'd1);
    chk("arst_done",  32'(cpu_done),  32'd0);
    step();
    rst = 1'b0;
    last_rdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_done",  32'(cpu_done),  32'd0);
      chk("post_rst_ready", 32'(cpu_ready), 32'd1);
    end
    chk("post_rst_rdata", 32'(cpu_rdata), 32'd0);
    post_rst = '{1'b0, 16'hC0DE, 16'h0000, 16'h4321, 1, 4'b0000, 1'b0};
    run_txn(post_rst);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
